// File: rtl/i2s_tdm_rx.sv
// I2S / TDM serial audio receiver: oversamples sck/ws/sd on clk, deserialises
// per-slot words and hands them out through a one-deep valid/ready register.
module i2s_tdm_rx #(
  parameter int unsigned AUDIO_DW    = 8,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CH_W        = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                sck_i,
  input  logic                ws_i,
  input  logic                sd_i,
  output logic [AUDIO_DW-1:0] sample_data,
  output logic [CH_W-1:0]     sample_ch,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                frame_err,
  output logic [15:0]         sample_count
);
  localparam int unsigned     BC_W      = $clog2(AUDIO_DW);
  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(AUDIO_DW - 1);
  localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(NUM_CH - 1);
  localparam bit              STEREO    = (NUM_CH == 2);

  typedef enum logic [1:0] {IDLE, HUNT, RUN} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
  logic                   sck_d, ws_q, pend_sync, wait_sync, word_done;
  logic [CH_W-1:0]        pend_slot, slot, word_ch;
  logic [AUDIO_DW-1:0]    shreg;
  logic [BC_W-1:0]        bit_cnt;

  logic                   sck_s, ws_s, sd_s;
  logic                   rise_c, sync_c, eff_sync_c;
  logic [CH_W-1:0]        sync_slot_c, eff_slot_c;

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign ws_s  = ws_sync[SYNC_STAGES-1];
  assign sd_s  = sd_sync[SYNC_STAGES-1];

  // In I2S mode the slot boundary lags the ws edge by one bit, so the sync
  // seen on one rise is applied (via pend_sync) on the following rise.
  always_comb begin
    rise_c      = sck_s & ~sck_d;
    sync_c      = rise_c & (STEREO ? (ws_s ^ ws_q) : (ws_s & ~ws_q));
    sync_slot_c = (STEREO && !ws_s) ? CH_W'(1) : '0;
    eff_sync_c  = mode ? sync_c : (rise_c & pend_sync);
    eff_slot_c  = mode ? sync_slot_c : pend_slot;
  end

  // Synchronisers, ws edge tracking and the capture FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      ws_sync   <= '0;
      sd_sync   <= '0;
      sck_d     <= 1'b0;
      ws_q      <= 1'b0;
      pend_sync <= 1'b0;
      pend_slot <= '0;
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      slot      <= '0;
      wait_sync <= 1'b0;
      word_done <= 1'b0;
      word_ch   <= '0;
      frame_err <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], ws_i};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sd_i};
      sck_d     <= sck_s;
      word_done <= 1'b0;
      if (rise_c) begin
        ws_q      <= ws_s;
        pend_sync <= sync_c;
        pend_slot <= sync_slot_c;
      end
      if (!en) begin
        state     <= IDLE;
        shreg     <= '0;
        bit_cnt   <= '0;
        slot      <= '0;
        wait_sync <= 1'b0;
        frame_err <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= HUNT;
          HUNT: begin
            if (eff_sync_c && eff_slot_c == '0) begin
              state     <= RUN;
              shreg     <= AUDIO_DW'(sd_s);
              bit_cnt   <= BC_W'(1);
              slot      <= '0;
              wait_sync <= 1'b0;
            end
          end
          RUN: begin
            if (eff_sync_c) begin
              // Realign to the sync; a mismatch means the partial word is lost.
              if (bit_cnt != '0 || slot != eff_slot_c) frame_err <= 1'b1;
              shreg     <= AUDIO_DW'(sd_s);
              bit_cnt   <= BC_W'(1);
              slot      <= eff_slot_c;
              wait_sync <= 1'b0;
            end else if (rise_c && !wait_sync) begin
              shreg <= {shreg[AUDIO_DW-2:0], sd_s};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt   <= '0;
                word_done <= 1'b1;
                word_ch   <= slot;
                slot      <= (slot == LAST_SLOT) ? '0 : slot + CH_W'(1);
                // Padding bits up to the next sync are ignored.
                wait_sync <= STEREO || (slot == LAST_SLOT);
              end else begin
                bit_cnt <= bit_cnt + BC_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // One-deep output register with sticky overrun and accept counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      sample_count <= '0;
    end else if (!en) begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      sample_count <= '0;
    end else begin
      if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
        sample_count <= sample_count + 16'd1;
      end
      if (word_done) begin
        if (!sample_valid || sample_ready) begin
          sample_data  <= shreg;
          sample_ch    <= word_ch;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/i2s_tdm_rx.md
Name: i2s_tdm_rx

Overview:
- Synthesisable, parametrised I2S/TDM audio receiver; generalises the two-channel, fixed-width I2S capture used to check the KS synth audio output.
- Oversamples the external sck/ws/sd on the system clock and deserialises AUDIO_DW-bit words for NUM_CH slots per frame.
- Supports Philips I2S (one-bit delay) and left-justified framing.
- Delivers words with channel tags over a valid/ready handshake, and flags overruns and framing errors.

Parameters:
AUDIO_DW, 8, bits per slot/word (4..32)
NUM_CH, 2, slots per frame (2..8); 2 = stereo I2S, >2 = TDM with ws as frame-sync
SYNC_STAGES, 2, synchroniser flops on sck_i/ws_i/sd_i (>=2)
CH_W, $clog2(NUM_CH), channel index width (derived; do not override)

Ports:
clk  in  1  system clock; must be >= 4x sck frequency
rst_n  in  1  asynchronous active-low reset
en  in  1  receiver enable; low = flush to IDLE, clear sticky flags
mode  in  1  0 = I2S (MSB one sck after ws edge), 1 = left-justified (MSB on ws edge)
sck_i  in  1  external bit clock, asynchronous
ws_i  in  1  external word select / frame sync, asynchronous
sd_i  in  1  serial data, MSB first, valid on sck rising edge
sample_data  out  AUDIO_DW  received word
sample_ch  out  CH_W  slot index of sample_data
sample_valid  out  1  word available
sample_ready  in  1  consumer accepts when valid&&ready at posedge clk
overrun  out  1  sticky: word completed while holding register full
frame_err  out  1  sticky: sync seen off frame boundary
sample_count  out  16  words accepted since en rose, wraps at 0xFFFF->0

Behaviour:
- Reset (rst_n low, async): all outputs 0, FSM IDLE, synchronisers 0, bit/slot counters 0.
- Synchronise sck_i, ws_i and sd_i through SYNC_STAGES flops each.
- One-cycle strobe rise = synced sck 0->1. All capture happens only on rise cycles.
- ws is sampled on each rise (ws_q = previous value).
- sync = rise && (ws != ws_q).
  - NUM_CH==2: both edges sync. Rising ws starts slot 0 (left); falling ws starts slot 1 (right).
  - NUM_CH>2: only the ws 0->1 edge starts slot 0.
- Bit alignment:
  - mode=1: the sd captured on the sync rise is slot MSB.
  - mode=0: the MSB is captured on the rise after sync. The sync rise captures the previous slot's LSB.
- FSM:
  - IDLE: wait for en=1, then go to HUNT.
  - HUNT: discard bits until the first slot-0 sync, then go to RUN with bit_cnt=0, slot=0.
  - RUN: shift sd into shreg on each aligned rise and increment bit_cnt. At bit_cnt==AUDIO_DW-1, the word completes: bit_cnt<=0 and slot<=slot+1, wrapping at NUM_CH-1 -> 0.
  - en low from any state: go to IDLE next clk. Clear shreg, counters, overrun, frame_err and sample_count. Drop sample_valid. A partial word is discarded.
- Framing check in RUN:
  - A sync whose expected slot start does not coincide with bit_cnt==0 and the matching slot index sets frame_err. The receiver then realigns to the sync's slot with bit_cnt=0.
  - A slot-0 sync arriving exactly on the frame boundary is normal.
  - In TDM, extra sck bits after slot NUM_CH-1 and before the next sync are ignored; no error.
- Output register (one deep):
  - When a word completes: if sample_valid==0, or sample_ready==1 in the same cycle, load sample_data/sample_ch and set sample_valid the next clk.
  - Otherwise drop the new word and set overrun.
  - Latency: sample_valid is high SYNC_STAGES+2 clk after the raw sck rise carrying the LSB.
- Accept: valid&&ready clears sample_valid (unless reloaded the same cycle) and increments sample_count.
- sample_data/sample_ch stay stable while valid&&!ready.
- Simultaneous word-complete and sync on the same rise (mode=0): complete the old word first, then apply the sync alignment. No error if aligned.

Test Plan:
- Reset/idle: rst_n low mid-frame, en=1 -> all outputs 0 within 1 clk of rst_n fall; sample_valid stays 0 until the first full slot after a slot-0 sync.
- Stereo I2S (AUDIO_DW=8, NUM_CH=2, mode=0, sck=clk/16, ready=1): send L=0xA5, R=0x3C for 4 frames -> words alternate ch0=0xA5, ch1=0x3C; sample_count=8; frame_err=0, overrun=0.
- Left-justified: same stimulus with mode=1 and data driven without delay -> identical words. With mode=0 on LJ data -> words shifted by 1 bit (0xA5 on the wire reads as 0x4B/...), demonstrating alignment.
- TDM (NUM_CH=4, AUDIO_DW=16): one-sck ws pulse per frame, slots 0x1111/0x2222/0x3333/0x4444 plus 8 idle bits -> ch0..3 in order with correct values; no frame_err.
- Backpressure: hold ready=0 across 3 word completions -> first word held stable, overrun=1, remaining words dropped. Then ready=1 -> first word accepted; sample_count +1.
- Framing error: flip ws 3 bits early in slot 1 -> frame_err=1, partial word discarded, next words correct. Pulse en low for 1 clk -> frame_err=0, overrun=0, sample_count=0, FSM HUNT.
